cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the common data bus (CDB) between result producers (ALU, memory unit) in the Tomasulo datapath.
- Each producer pushes a completed result into a private FIFO. A round-robin arbiter picks one result per cycle and drives it as a registered broadcast (cdb_valid/cdb_data) to the reservation station's store_cdb/solution inputs.
- The same broadcast drives the register-file write port.
- Result word format: [22:19] destination register, [18:16] reservation-station tag, [15:0] data.

Parameters:
- NUM_REQ, 2, number of producers (index 0 = ALU, 1 = memory); range 2..4.
- DEPTH, 2, entries per producer FIFO; power of two, at least 2.
- WIDTH, 23, result word width.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  producer i offers a result
- req_data  in  NUM_REQ*WIDTH  producer i result in slice [i*WIDTH +: WIDTH]
- req_ready  out  NUM_REQ  FIFO i can accept a result
- cdb_hold  in  1  consumer stall; no broadcast issued while high
- cdb_valid  out  1  broadcast strobe (feeds store_cdb)
- cdb_data  out  WIDTH  broadcast word (feeds solution)
- grant_id  out  2  index of the producer whose word is on the CDB
- rf_we  out  1  register-file write enable
- rf_addr  out  4  register-file write address
- rf_data  out  16  register-file write data
- busy  out  1  any FIFO non-empty or cdb_valid high

Behaviour:
- Reset: on a clock edge with reset_n low:
  - all FIFOs are emptied (pointers and counts = 0); rr_ptr = 0.
  - cdb_valid, cdb_data, grant_id, rf_we, rf_addr, rf_data = 0.
  - req_ready = 0 while reset_n is low. busy = 0 after reset.
  - Reset mid-operation discards all queued results with no broadcast.
- FIFO i:
  - req_ready[i] = reset_n && (count_i < DEPTH), combinational from registered count.
  - Push on edge when req_valid[i] && req_ready[i]; producers must hold data until accepted.
  - Pop when granted. Push and pop on the same edge leaves count unchanged, with data ordering preserved.
  - Pointers wrap modulo DEPTH. There is no fall-through: a word pushed at edge k is first eligible for arbitration at edge k+1.
- Arbitration, evaluated each edge:
  - eligible[i] = count_i != 0.
  - If cdb_hold == 0 and any eligible: the winner w is the first eligible index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ. Then:
    - pop FIFO w; cdb_valid <= 1; cdb_data <= head_w; grant_id <= w;
    - rf_we <= 1; rf_addr <= head_w[22:19]; rf_data <= head_w[15:0];
    - rr_ptr <= (w+1) mod NUM_REQ.
  - Otherwise: cdb_valid <= 0 and rf_we <= 0. cdb_data, grant_id, rf_addr and rf_data hold their last values. rr_ptr is unchanged.
- Latency and throughput:
  - Minimum latency is acceptance at edge k to cdb_valid high for the cycle after edge k+1.
  - One broadcast per cycle maximum; cdb_valid is a single-cycle strobe per word.
  - Back-to-back broadcasts are allowed.
- cdb_hold:
  - Takes effect at the next edge. A broadcast already registered still completes its cycle.
  - While held, FIFOs keep accepting until full.
- Fairness:
  - With all producers continuously eligible, grants rotate 0,1,...,NUM_REQ-1.
  - No producer waits more than NUM_REQ-1 grants once at head.
- Words are passed unmodified; the arbiter does no tag checking.
- busy = (|count) || cdb_valid.

Test Plan:
- Reset then single push: req_valid[0] with req_data[0] = 23'h1A_0042 at edge 1 → cdb_valid=1 in the cycle after edge 2 with cdb_data=23'h1A_0042, grant_id=0, rf_we=1, rf_addr=4'h3, rf_data=16'h0042; cdb_valid=0 the next cycle.
- Simultaneous requests: both producers push at the same edge (ALU 23'h08_0001, MEM 23'h11_0002) → broadcasts on consecutive cycles, ALU first (rr_ptr=0), then MEM; rr_ptr ends at 0.
- Fairness under saturation: both producers stream continuously → grant_id alternates 0,1,0,1 for 8 cycles; no gaps in cdb_valid.
- Full/backpressure: cdb_hold=1, push 3 words to producer 1 → req_ready[1]=0 after 2 accepts and the third word is held by the producer. Release cdb_hold → 3 words broadcast in push order, and req_ready[1] returns to 1 the edge after the first pop.
- Hold mid-stream: raise cdb_hold while 2 words are queued → the in-flight strobe completes, then no cdb_valid until cdb_hold=0; rr_ptr is unchanged across the hold.
- Reset mid-operation: FIFOs hold 3 words and reset_n is pulled low for 1 edge → cdb_valid=0, busy=0, req_ready=0 during reset; no queued word ever appears on the CDB afterward.

Source files
------------

// File: rtl/cdb_arbiter.sv
// CDB arbiter: per-producer result FIFOs feeding a round-robin picker that
// issues one registered broadcast per cycle to the reservation stations and register file.
module cdb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DEPTH   = 2,
  parameter int WIDTH   = 23
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     cdb_hold,
  output logic                     cdb_valid,
  output logic [WIDTH-1:0]         cdb_data,
  output logic [1:0]               grant_id,
  output logic                     rf_we,
  output logic [3:0]               rf_addr,
  output logic [15:0]              rf_data,
  output logic                     busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   mem_r    [NUM_REQ][DEPTH];
  logic [PW-1:0]      wr_ptr_r [NUM_REQ];
  logic [PW-1:0]      rd_ptr_r [NUM_REQ];
  logic [CW-1:0]      count_r  [NUM_REQ];
  logic [1:0]         rr_ptr_r;

  logic [NUM_REQ-1:0] eligible_s;
  logic [NUM_REQ-1:0] push_s;
  logic [NUM_REQ-1:0] pop_s;
  logic               found_s;
  logic               grant_s;
  logic [1:0]         win_idx_s;
  logic [1:0]         rr_next_s;
  logic [WIDTH-1:0]   head_s;

  // Per-FIFO status and handshake decode
  always_comb begin
    eligible_s = '0;
    req_ready  = '0;
    push_s     = '0;
    pop_s      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible_s[i] = (count_r[i] != CW'(0));
      req_ready[i]  = reset_n && (count_r[i] < CW'(DEPTH));
      push_s[i]     = req_valid[i] && req_ready[i];
      pop_s[i]      = grant_s && (win_idx_s == 2'(i));
    end
  end

  // Round-robin pick: scan from rr_ptr upward first, then wrap to the low indices
  always_comb begin
    found_s   = 1'b0;
    win_idx_s = 2'd0;
    head_s    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_s && eligible_s[i] && (2'(i) >= rr_ptr_r)) begin
        found_s   = 1'b1;
        win_idx_s = 2'(i);
        head_s    = mem_r[i][rd_ptr_r[i]];
      end else begin
        found_s = found_s;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_s && eligible_s[i]) begin
        found_s   = 1'b1;
        win_idx_s = 2'(i);
        head_s    = mem_r[i][rd_ptr_r[i]];
      end else begin
        found_s = found_s;
      end
    end
    grant_s = found_s && !cdb_hold;
    if (win_idx_s == 2'(NUM_REQ - 1)) begin
      rr_next_s = 2'd0;
    end else begin
      rr_next_s = win_idx_s + 2'd1;
    end
  end

  // FIFO storage; contents need no reset because counts gate visibility
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push_s[i]) begin
        mem_r[i][wr_ptr_r[i]] <= req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        wr_ptr_r[i] <= '0;
        rd_ptr_r[i] <= '0;
        count_r[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (push_s[i]) wr_ptr_r[i] <= wr_ptr_r[i] + PW'(1);
        if (pop_s[i])  rd_ptr_r[i] <= rd_ptr_r[i] + PW'(1);
        case ({push_s[i], pop_s[i]})
          2'b10:   count_r[i] <= count_r[i] + CW'(1);
          2'b01:   count_r[i] <= count_r[i] - CW'(1);
          default: count_r[i] <= count_r[i];
        endcase
      end
    end
  end

  // Registered broadcast; payload fields hold their last value between strobes
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rr_ptr_r  <= 2'd0;
      cdb_valid <= 1'b0;
      cdb_data  <= '0;
      grant_id  <= 2'd0;
      rf_we     <= 1'b0;
      rf_addr   <= 4'd0;
      rf_data   <= 16'd0;
    end else if (grant_s) begin
      rr_ptr_r  <= rr_next_s;
      cdb_valid <= 1'b1;
      cdb_data  <= head_s;
      grant_id  <= win_idx_s;
      rf_we     <= 1'b1;
      rf_addr   <= head_s[22:19];
      rf_data   <= head_s[15:0];
    end else begin
      cdb_valid <= 1'b0;
      rf_we     <= 1'b0;
    end
  end

  assign busy = (|eligible_s) || cdb_valid;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: tests queue predicted broadcasts, a negedge
// monitor pops and checks them, and each test adds its own timing checks.
module tb_cdb_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [45:0] req_data;
  logic [1:0]  req_ready;
  logic        cdb_hold;
  logic        cdb_valid;
  logic [22:0] cdb_data;
  logic [1:0]  grant_id;
  logic        rf_we;
  logic [3:0]  rf_addr;
  logic [15:0] rf_data;
  logic        busy;

  typedef struct packed {
    logic [22:0] d;
    logic [1:0]  g;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  cdb_arbiter #(.NUM_REQ(2), .DEPTH(2), .WIDTH(23)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .cdb_hold(cdb_hold), .cdb_valid(cdb_valid),
    .cdb_data(cdb_data), .grant_id(grant_id), .rf_we(rf_we), .rf_addr(rf_addr),
    .rf_data(rf_data), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [22:0] word(int p, int n);
    return {4'(p * 8 + n), 3'(n), 16'(16'h1000 * (p + 1) + n)};
  endfunction

  // Every broadcast must match the next predicted word
  always @(negedge clock) begin
    if (cdb_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_bcast got=%h gid=%0d expected none", cdb_data, grant_id);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (cdb_data !== e.d || grant_id !== e.g || rf_we !== 1'b1 ||
            rf_addr !== e.d[22:19] || rf_data !== e.d[15:0]) begin
          bad++;
          $display("FAIL bcast got=%h gid=%0d we=%b addr=%h rf=%h expected=%h gid=%0d",
                   cdb_data, grant_id, rf_we, rf_addr, rf_data, e.d, e.g);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset_n   = 1'b0;
    req_valid = 2'b00;
    req_data  = '0;
    cdb_hold  = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL leftover_expected got=%0d expected=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = 2'b00;
    req_data  = '0;
    cdb_hold  = 1'b0;
    cyc();
    @(negedge clock);
    total++;
    if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b expected=00", req_ready); end
    total++;
    if (cdb_valid !== 1'b0 || rf_we !== 1'b0 || cdb_data !== 23'd0 || grant_id !== 2'd0 ||
        rf_addr !== 4'd0 || rf_data !== 16'd0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b we=%b d=%h g=%0d a=%h rd=%h expected all 0",
               cdb_valid, rf_we, cdb_data, grant_id, rf_addr, rf_data);
    end
    cyc();
    reset_n = 1'b1;
    @(negedge clock);
    total++;
    if (req_ready !== 2'b11) begin bad++; $display("FAIL post_reset_ready got=%b expected=11", req_ready); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b expected=0", busy); end
  endtask

  task automatic test_single();
    apply_reset();
    req_valid        = 2'b01;
    req_data[22:0]   = 23'h1A_0042;
    sb.push_back('{d: 23'h1A_0042, g: 2'd0});
    cyc();
    req_valid = 2'b00;
    @(negedge clock);
    total++;
    if (cdb_valid !== 1'b0) begin bad++; $display("FAIL single_no_fallthrough got=%b expected=0", cdb_valid); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b expected=1", busy); end
    cyc();
    @(negedge clock);
    total++;
    if (cdb_valid !== 1'b1 || cdb_data !== 23'h1A_0042 || grant_id !== 2'd0 ||
        rf_we !== 1'b1 || rf_addr !== 4'h3 || rf_data !== 16'h0042) begin
      bad++;
      $display("FAIL single_bcast got v=%b d=%h g=%0d we=%b a=%h rd=%h expected 1 1a0042 0 1 3 0042",
               cdb_valid, cdb_data, grant_id, rf_we, rf_addr, rf_data);
    end
    cyc();
    @(negedge clock);
    total++;
    if (cdb_valid !== 1'b0 || rf_we !== 1'b0) begin
      bad++;
      $display("FAIL single_strobe_end got v=%b we=%b expected 0 0", cdb_valid, rf_we);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    req_valid       = 2'b11;
    req_data[22:0]  = 23'h08_0001;
    req_data[45:23] = 23'h11_0002;
    sb.push_back('{d: 23'h08_0001, g: 2'd0});
    sb.push_back('{d: 23'h11_0002, g: 2'd1});
    cyc();
    req_valid = 2'b00;
    cyc();
    @(negedge clock);
    total++;
    if (cdb_valid !== 1'b1 || grant_id !== 2'd0) begin
      bad++; $display("FAIL simul_first got v=%b g=%0d expected 1 0", cdb_valid, grant_id);
    end
    cyc();
    @(negedge clock);
    total++;
    if (cdb_valid !== 1'b1 || grant_id !== 2'd1) begin
      bad++; $display("FAIL simul_second got v=%b g=%0d expected 1 1", cdb_valid, grant_id);
    end
    // rr_ptr is back at 0: a fresh simultaneous pair must again favour the ALU
    req_valid       = 2'b11;
    req_data[22:0]  = word(0, 7);
    req_data[45:23] = word(1, 7);
    sb.push_back('{d: word(0, 7), g: 2'd0});
    sb.push_back('{d: word(1, 7), g: 2'd1});
    cyc();
    req_valid = 2'b00;
    repeat (4) cyc();
  endtask

  task automatic test_fairness();
    int sent[2];
    int vcount, first, last;
    logic [1:0] rdy;
    apply_reset();
    for (int n = 0; n < 5; n++) begin
      sb.push_back('{d: word(0, n), g: 2'd0});
      sb.push_back('{d: word(1, n), g: 2'd1});
    end
    sent = '{0, 0};
    vcount = 0; first = 0; last = 0;
    req_valid       = 2'b11;
    req_data[22:0]  = word(0, 0);
    req_data[45:23] = word(1, 0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      rdy = req_ready;
      if (cdb_valid === 1'b1) begin
        if (vcount == 0) first = c;
        last = c;
        vcount++;
      end
      cyc();
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && rdy[i]) sent[i]++;
        req_valid[i] = (sent[i] < 5);
        if (sent[i] < 5) req_data[i*23 +: 23] = word(i, sent[i]);
      end
    end
    total++;
    if (vcount != 10) begin bad++; $display("FAIL fair_count got=%0d expected=10", vcount); end
    total++;
    if (last - first + 1 != 10) begin bad++; $display("FAIL fair_gapless got span=%0d expected=10", last - first + 1); end
  endtask

  task automatic test_full();
    apply_reset();
    cdb_hold        = 1'b1;
    req_valid       = 2'b10;
    req_data[45:23] = word(1, 0);
    for (int n = 0; n < 3; n++) sb.push_back('{d: word(1, n), g: 2'd1});
    cyc();
    req_data[45:23] = word(1, 1);
    cyc();
    req_data[45:23] = word(1, 2);
    @(negedge clock);
    total++;
    if (req_ready[1] !== 1'b0) begin bad++; $display("FAIL full_ready got=%b expected=0", req_ready[1]); end
    cyc();
    @(negedge clock);
    total++;
    if (req_ready[1] !== 1'b0 || cdb_valid !== 1'b0) begin
      bad++; $display("FAIL full_held got rdy=%b v=%b expected 0 0", req_ready[1], cdb_valid);
    end
    cyc();
    cdb_hold = 1'b0;
    cyc();
    @(negedge clock);
    total++;
    if (req_ready[1] !== 1'b1 || cdb_valid !== 1'b1) begin
      bad++; $display("FAIL full_release got rdy=%b v=%b expected 1 1", req_ready[1], cdb_valid);
    end
    cyc();
    req_valid = 2'b00;
    cyc();
    cyc();
    @(negedge clock);
    total++;
    if (cdb_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL full_drain got v=%b busy=%b expected 0 0", cdb_valid, busy);
    end
  endtask

  task automatic test_hold_mid();
    apply_reset();
    cdb_hold        = 1'b1;
    req_valid       = 2'b11;
    req_data[22:0]  = word(0, 0);
    req_data[45:23] = word(1, 0);
    sb.push_back('{d: word(0, 0), g: 2'd0});
    sb.push_back('{d: word(1, 0), g: 2'd1});
    sb.push_back('{d: word(0, 1), g: 2'd0});
    cyc();
    req_valid      = 2'b01;
    req_data[22:0] = word(0, 1);
    cyc();
    req_valid = 2'b00;
    cdb_hold  = 1'b0;
    cyc();
    cdb_hold = 1'b1;
    @(negedge clock);
    total++;
    if (cdb_valid !== 1'b1 || grant_id !== 2'd0) begin
      bad++; $display("FAIL hold_inflight got v=%b g=%0d expected 1 0", cdb_valid, grant_id);
    end
    for (int c = 0; c < 3; c++) begin
      cyc();
      @(negedge clock);
      total++;
      if (cdb_valid !== 1'b0) begin bad++; $display("FAIL hold_quiet cycle=%0d got=%b expected=0", c, cdb_valid); end
    end
    cdb_hold = 1'b0;
    cyc();
    @(negedge clock);
    total++;
    if (cdb_valid !== 1'b1 || grant_id !== 2'd1) begin
      bad++; $display("FAIL hold_rr_kept got v=%b g=%0d expected 1 1", cdb_valid, grant_id);
    end
    repeat (3) cyc();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    cdb_hold        = 1'b1;
    req_valid       = 2'b11;
    req_data[22:0]  = word(0, 3);
    req_data[45:23] = word(1, 3);
    cyc();
    req_valid      = 2'b01;
    req_data[22:0] = word(0, 4);
    cyc();
    req_valid = 2'b00;
    @(negedge clock);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_before got=%b expected=1", busy); end
    cyc();
    reset_n  = 1'b0;
    cdb_hold = 1'b0;
    @(negedge clock);
    total++;
    if (req_ready !== 2'b00) begin bad++; $display("FAIL rmid_ready got=%b expected=00", req_ready); end
    cyc();
    reset_n = 1'b1;
    @(negedge clock);
    total++;
    if (cdb_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rmid_cleared got v=%b busy=%b expected 0 0", cdb_valid, busy);
    end
    repeat (6) cyc();
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_full();
    test_hold_mid();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL final_scoreboard got=%0d expected=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
